pool_window_ctrl: RTL and testbench
===================================

Name: pool_window_ctrl

Overview:
- Sequencer for the max-pooling datapath.
- Scans a row-major input feature map in on-chip memory and issues one read per cycle to gather each non-overlapping POOL_DIM x POOL_DIM window.
- Presents each assembled window to the pooling unit, tracks that unit's fixed pipeline latency, and writes each pooled result to sequential output-map addresses.
- Sits between the IFM buffer, the pooling unit and the OFM buffer; driven by the layer controller through a start/busy/done handshake.

Parameters:
- DATA_WIDTH, 8, signed pixel width.
- ADDR_WIDTH, 12, IFM/OFM address width.
- DIM_WIDTH, 8, width of the runtime height and width config.
- POOL_DIM, 2, window edge; window holds POOL_DIM*POOL_DIM pixels; stride equals POOL_DIM.
- POOL_LAT, 4, cycles from win_valid to the matching pool_result being valid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle start pulse; ignored while busy.
- cfg_h  in  DIM_WIDTH  IFM height; sampled on an accepted start.
- cfg_w  in  DIM_WIDTH  IFM width; sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last result is written.
- ifm_rd_en  out  1  IFM read strobe.
- ifm_rd_addr  out  ADDR_WIDTH  IFM read address.
- ifm_rd_data  in  DATA_WIDTH  IFM data; valid 1 cycle after ifm_rd_en.
- win_valid  out  1  window valid for the pooling unit.
- win_data  out  POOL_DIM*POOL_DIM*DATA_WIDTH  packed window; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- pool_result  in  DATA_WIDTH  pooling unit output.
- ofm_we  out  1  OFM write strobe.
- ofm_addr  out  ADDR_WIDTH  OFM write address.
- ofm_data  out  DATA_WIDTH  OFM write data.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters 0; latency delay line cleared.
- States:
  - IDLE: start=1 latches cfg and moves to READ. If cfg_h<POOL_DIM or cfg_w<POOL_DIM, go to DONE instead.
  - READ: one read per cycle, ifm_rd_en=1, with no bubbles between windows. After the last read of the last window, go to DRAIN.
  - DRAIN: wait until the delay line is empty, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Scan order:
  - Windows are row-major: window row r, window column c.
  - Inside a window, element k = dr*POOL_DIM+dc, also row-major.
  - ifm_rd_addr = (r*POOL_DIM+dr)*cfg_w + c*POOL_DIM + dc, computed with ADDR_WIDTH arithmetic.
- Odd sizes: windows per row = floor(cfg_w/POOL_DIM); window rows = floor(cfg_h/POOL_DIM). Trailing row and column pixels are never read.
- Window timing:
  - The element read in cycle t is captured into slot k at the end of cycle t+1.
  - win_valid=1 in cycle t+2, where t is the cycle of the window's last read. win_data is stable in that cycle.
  - win_valid is otherwise 0, so at most one window per POOL_DIM*POOL_DIM cycles.
- Result timing:
  - A POOL_LAT-deep valid delay line is fed by win_valid.
  - Its output asserts ofm_we; ofm_data = pool_result in the same cycle.
  - ofm_addr starts at 0 for each layer and increments after every write.
  - Latency from last read to write: 2+POOL_LAT cycles.
- Done: the done pulse occurs the cycle after the final ofm_we. Total writes = floor(H/POOL_DIM)*floor(W/POOL_DIM).
- No backpressure: the OFM buffer must accept every write.
- Simultaneous events: start in the same cycle as done is ignored; start is only accepted in IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no further reads or writes; in-flight results are discarded.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: ofm_data = 0 when pool_result is negative (signed), else pool_result; no added latency.
- Undefined: ofm_data = pool_result unmodified.

Test Plan:
- 4x4 map holding values 0..15, POOL_LAT=4, bench pooling model = max of window -> writes 5,7,13,15 at ofm_addr 0..3. Read addresses run 0,1,4,5,2,3,6,7,8,9,12,13,... One done pulse, busy low after it.
- 5x5 map -> exactly 4 writes; addresses 4,9,14,19,20..24 never read; first window's last read to ofm_we = 6 cycles.
- 4x4 map, all values -3 -> 4 writes of -3 without POOL_RELU_EN; 4 writes of 0 with it.
- cfg_w=1, cfg_h=8 -> done asserted 1 cycle after start; no ifm_rd_en, win_valid or ofm_we.
- start pulsed again mid-layer -> ignored, write count unchanged; rst asserted mid-READ -> outputs 0 the next cycle, no further writes; a new start then runs a full layer with ofm_addr from 0.

Source files
------------

// File: rtl/pool_window_if.sv
// pool_window_if
//   Bundles the sequencer's layer handshake with its buffer and pooling-unit
//   connections.
//   master : the pool_window_ctrl side (issues reads, presents windows,
//            writes results).
//   slave  : the environment side (layer controller, IFM/OFM buffers,
//            pooling unit).
//   Signals: start, cfg_h, cfg_w, busy, done        - layer handshake
//            ifm_rd_en, ifm_rd_addr, ifm_rd_data     - IFM buffer read port
//            win_valid, win_data, pool_result        - pooling unit
//            ofm_we, ofm_addr, ofm_data              - OFM buffer write port
`timescale 1ns/1ps
interface pool_window_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 8,
  parameter int POOL_DIM   = 2
);
  logic                                   start;
  logic [DIM_WIDTH-1:0]                   cfg_h;
  logic [DIM_WIDTH-1:0]                   cfg_w;
  logic                                   busy;
  logic                                   done;
  logic                                   ifm_rd_en;
  logic [ADDR_WIDTH-1:0]                  ifm_rd_addr;
  logic [DATA_WIDTH-1:0]                  ifm_rd_data;
  logic                                   win_valid;
  logic [POOL_DIM*POOL_DIM*DATA_WIDTH-1:0] win_data;
  logic [DATA_WIDTH-1:0]                  pool_result;
  logic                                   ofm_we;
  logic [ADDR_WIDTH-1:0]                  ofm_addr;
  logic [DATA_WIDTH-1:0]                  ofm_data;

  modport master (
    input  start, cfg_h, cfg_w, ifm_rd_data, pool_result,
    output busy, done, ifm_rd_en, ifm_rd_addr, win_valid, win_data,
           ofm_we, ofm_addr, ofm_data
  );

  modport slave (
    output start, cfg_h, cfg_w, ifm_rd_data, pool_result,
    input  busy, done, ifm_rd_en, ifm_rd_addr, win_valid, win_data,
           ofm_we, ofm_addr, ofm_data
  );
endinterface

// File: rtl/pool_window_ctrl.sv
// pool_window_ctrl
//   Max-pooling window sequencer. Scans a row-major IFM one read per cycle,
//   assembles each non-overlapping POOL_DIM x POOL_DIM window, hands it to
//   the pooling unit, tracks the unit's POOL_LAT latency and writes each
//   result to consecutive OFM addresses.
//   Ports: clk, rst (synchronous, active-high)
//          bus (pool_window_if.master): start/cfg_h/cfg_w/busy/done,
//          IFM read port, window/pool_result, OFM write port.
//   Optional: define POOL_RELU_EN to clamp negative pooled results to 0.
`timescale 1ns/1ps
module pool_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 8,
  parameter int POOL_DIM   = 2,
  parameter int POOL_LAT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  pool_window_if.master bus
);
  localparam int WIN = POOL_DIM * POOL_DIM;
  localparam int PW  = (POOL_DIM > 1) ? $clog2(POOL_DIM) : 1;
  localparam int KW  = (WIN > 1) ? $clog2(WIN) : 1;
  // All delay-line stages except the output stage.
  localparam logic [POOL_LAT-1:0] DL_INNER = POOL_LAT'((64'd1 << (POOL_LAT - 1)) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [DIM_WIDTH-1:0]  win_rows_q, win_cols_q, r_q, c_q;
  logic [PW-1:0]         dr_q, dc_q;
  logic [KW-1:0]         k_q;
  logic [ADDR_WIDTH-1:0] w_q, w_pm1_q, row_addr_q, col_addr_q, ofm_addr_q;
  logic                  rd_v_q, rd_last_q, win_valid_q;
  logic [KW-1:0]         rd_k_q;
  logic [POOL_LAT-1:0]   dl_q;
  logic [DATA_WIDTH-1:0] win_q [WIN];

  logic start_ok, degenerate, last_dc, last_dr, last_c, last_r, layer_last, pending;
  logic busy_d, done_d, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [DATA_WIDTH-1:0] result_d;

  assign start_ok   = (state_q == S_IDLE) && bus.start;
  assign degenerate = (bus.cfg_h < DIM_WIDTH'(POOL_DIM)) || (bus.cfg_w < DIM_WIDTH'(POOL_DIM));
  assign last_dc    = (dc_q == PW'(POOL_DIM - 1));
  assign last_dr    = (dr_q == PW'(POOL_DIM - 1));
  assign last_c     = (c_q == win_cols_q - 1'b1);
  assign last_r     = (r_q == win_rows_q - 1'b1);
  assign layer_last = last_dc && last_dr && last_c && last_r;
  // Anything still in flight that would produce a write after this cycle.
  assign pending    = rd_v_q || win_valid_q || (|(dl_q & DL_INNER));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = degenerate ? S_DONE : S_READ;
      S_READ: begin
        busy_d    = 1'b1;
        rd_en_d   = 1'b1;
        rd_addr_d = row_addr_q + col_addr_q;
        if (layer_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy_d = 1'b1;
        if (!pending) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address walk kept incremental: row_addr_q is the start of the current
  // pixel row, col_addr_q the column; no multiplier in the read path.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_rows_q <= '0; win_cols_q <= '0; r_q <= '0; c_q <= '0;
      dr_q <= '0; dc_q <= '0; k_q <= '0;
      w_q <= '0; w_pm1_q <= '0; row_addr_q <= '0; col_addr_q <= '0;
    end else if (start_ok) begin
      win_rows_q <= bus.cfg_h / DIM_WIDTH'(POOL_DIM);
      win_cols_q <= bus.cfg_w / DIM_WIDTH'(POOL_DIM);
      w_q        <= ADDR_WIDTH'(bus.cfg_w);
      w_pm1_q    <= ADDR_WIDTH'(ADDR_WIDTH'(bus.cfg_w) * ADDR_WIDTH'(POOL_DIM - 1));
      r_q <= '0; c_q <= '0; dr_q <= '0; dc_q <= '0; k_q <= '0;
      row_addr_q <= '0; col_addr_q <= '0;
    end else if (state_q == S_READ) begin
      k_q <= (k_q == KW'(WIN - 1)) ? '0 : k_q + 1'b1;
      if (!last_dc) begin
        dc_q       <= dc_q + 1'b1;
        col_addr_q <= col_addr_q + 1'b1;
      end else if (!last_dr) begin
        dc_q       <= '0;
        dr_q       <= dr_q + 1'b1;
        row_addr_q <= row_addr_q + w_q;
        col_addr_q <= col_addr_q - ADDR_WIDTH'(POOL_DIM - 1);
      end else begin
        dc_q <= '0;
        dr_q <= '0;
        if (!last_c) begin
          // Back up to the window's top row, step right to the next window.
          c_q        <= c_q + 1'b1;
          col_addr_q <= col_addr_q + 1'b1;
          row_addr_q <= row_addr_q - w_pm1_q;
        end else begin
          c_q        <= '0;
          r_q        <= r_q + 1'b1;
          col_addr_q <= '0;
          row_addr_q <= row_addr_q + w_q;
        end
      end
    end
  end

  // Read-response tracking: data returns one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v_q <= 1'b0; rd_last_q <= 1'b0; rd_k_q <= '0;
      win_valid_q <= 1'b0; dl_q <= '0; ofm_addr_q <= '0;
    end else begin
      rd_v_q      <= (state_q == S_READ);
      rd_last_q   <= (state_q == S_READ) && (k_q == KW'(WIN - 1));
      rd_k_q      <= k_q;
      win_valid_q <= rd_v_q && rd_last_q;
      dl_q        <= (dl_q << 1) | POOL_LAT'(win_valid_q);
      if (start_ok)               ofm_addr_q <= '0;
      else if (dl_q[POOL_LAT-1])  ofm_addr_q <= ofm_addr_q + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst)                                  win_q[gi] <= '0;
        else if (rd_v_q && (rd_k_q == KW'(gi)))   win_q[gi] <= bus.ifm_rd_data;
      end
      assign bus.win_data[gi*DATA_WIDTH +: DATA_WIDTH] = win_q[gi];
    end
  endgenerate

`ifdef POOL_RELU_EN
  assign result_d = bus.pool_result[DATA_WIDTH-1] ? '0 : bus.pool_result;
`else
  assign result_d = bus.pool_result;
`endif

  assign bus.busy        = busy_d;
  assign bus.done        = done_d;
  assign bus.ifm_rd_en   = rd_en_d;
  assign bus.ifm_rd_addr = rd_addr_d;
  assign bus.win_valid   = win_valid_q;
  assign bus.ofm_we      = dl_q[POOL_LAT-1];
  assign bus.ofm_addr    = ofm_addr_q;
  // Data held at 0 outside write cycles so idle/reset outputs are quiet.
  assign bus.ofm_data    = dl_q[POOL_LAT-1] ? result_d : '0;
endmodule

// File: tb/tb_pool_window_ctrl.sv
`timescale 1ns/1ps
module tb_pool_window_ctrl;
  localparam int DW = 8, AW = 12, DIMW = 8, P = 2, L = 4, WIN = P * P;
`ifdef POOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_window_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DIMW), .POOL_DIM(P)) bus ();
  pool_window_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DIMW), .POOL_DIM(P), .POOL_LAT(L))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  logic signed [DW-1:0] mem [0:(1<<AW)-1];
  logic signed [DW-1:0] pipe [L];

  // Cumulative monitor records; each layer looks only at entries past its base.
  int rd_addr_q[$], rd_cyc_q[$], wv_cyc_q[$], wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], done_cyc_q[$];
  int busy_cnt = 0;
  int rb, wb, vb, db, bb;

  always @(posedge clk) cyc <= cyc + 1;

  // IFM buffer: one-cycle read latency.
  always @(posedge clk) if (bus.ifm_rd_en) bus.ifm_rd_data <= mem[bus.ifm_rd_addr];

  function automatic logic signed [DW-1:0] win_max(input logic [WIN*DW-1:0] wd);
    logic signed [DW-1:0] m;
    m = $signed(wd[DW-1:0]);
    for (int k = 1; k < WIN; k++)
      if ($signed(wd[k*DW +: DW]) > m) m = $signed(wd[k*DW +: DW]);
    return m;
  endfunction

  // Pooling unit: fixed L-cycle latency from win_valid.
  always @(posedge clk) begin
    pipe[0] <= bus.win_valid ? win_max(bus.win_data) : 8'sh5a;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.pool_result = pipe[L-1];

  always @(negedge clk) if (!rst) begin
    if (bus.ifm_rd_en) begin rd_addr_q.push_back(int'(bus.ifm_rd_addr)); rd_cyc_q.push_back(cyc); end
    if (bus.win_valid) wv_cyc_q.push_back(cyc);
    if (bus.ofm_we) begin
      wr_addr_q.push_back(int'(bus.ofm_addr));
      wr_data_q.push_back(int'($signed(bus.ofm_data)));
      wr_cyc_q.push_back(cyc);
    end
    if (bus.done) done_cyc_q.push_back(cyc);
    if (bus.busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mark_bases();
    rb = rd_addr_q.size(); wb = wr_addr_q.size(); vb = wv_cyc_q.size();
    db = done_cyc_q.size(); bb = busy_cnt;
  endtask

  task automatic run_layer(input int h, input int w, input int restart_after);
    int nwin, s_cyc, a, m, v, exp_done, exp_busy, n;
    int exp_addr[$];
    int exp_data[$];
    nwin = (h / P) * (w / P);
    for (int r = 0; r < h / P; r++)
      for (int c = 0; c < w / P; c++) begin
        m = -1000;
        for (int dr = 0; dr < P; dr++)
          for (int dc = 0; dc < P; dc++) begin
            a = ((r * P + dr) * w + c * P + dc) % (1 << AW);
            exp_addr.push_back(a);
            v = int'(mem[a]);
            if (v > m) m = v;
          end
        exp_data.push_back((RELU && m < 0) ? 0 : m);
      end
    mark_bases();
    @(posedge clk); #1;
    bus.cfg_h = DIMW'(h); bus.cfg_w = DIMW'(w); bus.start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (restart_after > 0) begin
      repeat (restart_after) @(posedge clk);
      #1 bus.start = 1'b1; bus.cfg_h = 8'd2; bus.cfg_w = 8'd2;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    for (int i = 0; i < h * w + 60 && done_cyc_q.size() == db; i++) @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
    exp_done = (nwin == 0) ? s_cyc + 1 : s_cyc + nwin * WIN + 3 + L;
    exp_busy = (nwin == 0) ? 0 : nwin * WIN + 2 + L;
    check("done_count", done_cyc_q.size() - db, 1);
    if (done_cyc_q.size() > db) check("done_cycle", done_cyc_q[db] - s_cyc, exp_done - s_cyc);
    check("busy_cycles", busy_cnt - bb, exp_busy);
    check("busy_after", bus.busy, 0);
    check("read_count", rd_addr_q.size() - rb, exp_addr.size());
    n = rd_addr_q.size() - rb;
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      check($sformatf("rd_addr[%0d]", i), rd_addr_q[rb+i], exp_addr[i]);
      check($sformatf("rd_cyc[%0d]", i), rd_cyc_q[rb+i] - s_cyc, 1 + i);
    end
    check("win_count", wv_cyc_q.size() - vb, nwin);
    for (int j = 0; j < wv_cyc_q.size() - vb && j < nwin; j++)
      check($sformatf("win_cyc[%0d]", j), wv_cyc_q[vb+j] - s_cyc, (j + 1) * WIN + 2);
    check("write_count", wr_addr_q.size() - wb, nwin);
    for (int j = 0; j < wr_addr_q.size() - wb && j < nwin; j++) begin
      check($sformatf("wr_addr[%0d]", j), wr_addr_q[wb+j], j);
      check($sformatf("wr_data[%0d]", j), wr_data_q[wb+j], exp_data[j]);
      check($sformatf("wr_cyc[%0d]", j), wr_cyc_q[wb+j] - s_cyc, (j + 1) * WIN + 2 + L);
    end
    $display("layer h=%0d w=%0d restart=%0d: reads=%0d writes=%0d done=%0d",
             h, w, restart_after, rd_addr_q.size() - rb, wr_addr_q.size() - wb, done_cyc_q.size() - db);
  endtask

  initial begin
    int exp_wr4[4];
    int exp_rd8[8];
    int bad, h, w;
    exp_wr4 = '{5, 7, 13, 15};
    exp_rd8 = '{0, 1, 4, 5, 2, 3, 6, 7};
    bus.start = 1'b0; bus.cfg_h = '0; bus.cfg_w = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_en", bus.ifm_rd_en, 0);
    check("rst_rd_addr", bus.ifm_rd_addr, 0);
    check("rst_win_valid", bus.win_valid, 0);
    check("rst_ofm_we", bus.ofm_we, 0);
    check("rst_ofm_addr", bus.ofm_addr, 0);
    check("rst_ofm_data", bus.ofm_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 4x4 ramp 0..15
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    run_layer(4, 4, 0);
    for (int i = 0; i < 4; i++)
      if (wb + i < wr_data_q.size()) check($sformatf("ramp_wr[%0d]", i), wr_data_q[wb+i], exp_wr4[i]);
    for (int i = 0; i < 8; i++)
      if (rb + i < rd_addr_q.size()) check($sformatf("ramp_rd[%0d]", i), rd_addr_q[rb+i], exp_rd8[i]);

    // 5x5: trailing row/column never touched
    for (int i = 0; i < 25; i++) mem[i] = DW'($urandom);
    run_layer(5, 5, 0);
    bad = 0;
    for (int i = rb; i < rd_addr_q.size(); i++)
      if (rd_addr_q[i] % 5 == 4 || rd_addr_q[i] >= 20) bad++;
    check("odd_unread", bad, 0);

    // all -3
    for (int i = 0; i < 16; i++) mem[i] = -8'sd3;
    run_layer(4, 4, 0);
    for (int i = 0; i < 4; i++)
      if (wb + i < wr_data_q.size()) check($sformatf("neg_wr[%0d]", i), wr_data_q[wb+i], RELU ? 0 : -3);

    // degenerate width
    run_layer(8, 1, 0);

    // second start mid-layer is ignored
    for (int i = 0; i < 36; i++) mem[i] = DW'($urandom);
    run_layer(6, 6, 5);

    // reset in the middle of READ
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
    @(posedge clk); #1 bus.cfg_h = 8'd8; bus.cfg_w = 8'd8; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mark_bases();
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rd_en", bus.ifm_rd_en, 0);
    check("mid_rst_rd_addr", bus.ifm_rd_addr, 0);
    check("mid_rst_win_valid", bus.win_valid, 0);
    check("mid_rst_win_data_nz", (bus.win_data != '0), 0);
    check("mid_rst_ofm_we", bus.ofm_we, 0);
    check("mid_rst_ofm_addr", bus.ofm_addr, 0);
    repeat (30) @(posedge clk);
    #1;
    check("mid_rst_reads", rd_addr_q.size() - rb, 0);
    check("mid_rst_writes", wr_addr_q.size() - wb, 0);
    check("mid_rst_done", done_cyc_q.size() - db, 0);
    $display("reset mid-layer: reads=%0d writes=%0d after reset", rd_addr_q.size() - rb, wr_addr_q.size() - wb);
    run_layer(4, 6, 0);

    // randomized layers
    for (int t = 0; t < 10; t++) begin
      h = $urandom_range(1, 14);
      w = $urandom_range(1, 14);
      for (int i = 0; i < h * w; i++) mem[i] = DW'($urandom);
      run_layer(h, w, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
